// File: rtl/picorv32_sim_pkg.sv
// Shared definitions for the picorv32 simulation memory model:
// FSM state encoding, wait-mode selectors, default MMIO addresses and
// the xorshift32 step used for random wait-state generation.
package picorv32_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DBG
  } state_t;

  localparam int WAIT_NONE  = 0;
  localparam int WAIT_FIXED = 1;
  localparam int WAIT_RAND  = 2;

  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR    = 32'h2000_0000;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/picorv32_mem_model_if.sv
// Bundle of the picorv32 native memory bus, the console byte stream,
// the debug peek/poke port and the sticky status flags.
//  master : CPU / bench side (drives requests, consumes console)
//  slave  : memory model side
interface picorv32_mem_model_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;
  logic        dbg_valid;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ready;
  logic [7:0]  dbg_rdata;
  logic        exited;
  logic [31:0] exit_code;
  logic        err;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           con_ready, dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    input  mem_ready, mem_rdata, con_valid, con_data, dbg_ready, dbg_rdata,
           exited, exit_code, err
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           con_ready, dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    output mem_ready, mem_rdata, con_valid, con_data, dbg_ready, dbg_rdata,
           exited, exit_code, err
  );
endinterface

// File: rtl/picorv32_sim_fifo.sv
// Synchronous FIFO, parametrised width/depth (depth power of two, >= 2).
//  i_push/i_din : write side; a push on a full FIFO succeeds only when a
//                 pop happens in the same cycle
//  i_pop/o_dout : read side, o_dout shows the head entry
//  o_empty/o_full : occupancy flags
module picorv32_sim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          w_pop, w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_FULL);
  assign o_dout  = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/picorv32_mem_model.sv
// Simulation memory responder for the picorv32 native memory interface.
// Byte-lane RAM, selectable wait-state generation, console byte FIFO,
// sticky exit/error flags and a byte-wide debug port sharing the RAM.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : slave side of picorv32_mem_model_if (memory bus, console,
//               debug port, status)
module picorv32_mem_model import picorv32_sim_pkg::*; #(
  parameter int          MEM_BYTES    = 4194304,
  parameter int          WAIT_MODE    = WAIT_RAND,
  parameter int          FIXED_WAIT   = 3,
  parameter logic [31:0] LFSR_SEED    = 32'd314159265,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] EXIT_ADDR    = DEF_EXIT_ADDR,
  parameter int          CON_DEPTH    = 8
) (
  input logic                 clk,
  input logic                 reset,
  picorv32_mem_model_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);

  state_t      r_state;
  logic [31:0] r_addr, r_wdata, r_lfsr, r_rdata, r_exit_code, r_dbg_addr;
  logic [3:0]  r_wstrb;
  logic [7:0]  r_cnt, r_dbg_wdata, r_dbg_rdata;
  logic        r_dbg_we, r_mem_ready, r_dbg_ready, r_exited, r_err;
  logic [7:0]  r_ram [MEM_BYTES];

  logic          w_is_wr, w_is_con, w_is_exit, w_mmio, w_ram_ok, w_oor;
  logic          w_dbg_oor, w_wait_done, w_go, w_push, w_pop;
  logic          w_con_empty, w_con_full;
  logic [AW-1:0] w_idx, w_dbg_idx;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  // request decode on the captured address (bits [1:0] are don't-care)
  assign w_is_wr   = |r_wstrb;
  assign w_is_con  = ({r_addr[31:2], 2'b00} == CONSOLE_ADDR);
  assign w_is_exit = ({r_addr[31:2], 2'b00} == EXIT_ADDR);
  assign w_mmio    = w_is_con || w_is_exit;
  assign w_ram_ok  = !(|r_addr[31:AW]) && !w_mmio;
  assign w_oor     = (|r_addr[31:AW]) && !w_mmio;
  assign w_dbg_oor = |r_dbg_addr[31:AW];
  assign w_idx     = {r_addr[AW-1:2], 2'b00};
  assign w_dbg_idx = r_dbg_addr[AW-1:0];
  assign w_rd_word = {r_ram[w_idx | AW'(3)], r_ram[w_idx | AW'(2)],
                      r_ram[w_idx | AW'(1)], r_ram[w_idx]};

  always_comb begin
    w_wait_done = 1'b1;
    if (WAIT_MODE == WAIT_FIXED)     w_wait_done = (r_cnt == 8'd0);
    else if (WAIT_MODE == WAIT_RAND) w_wait_done = r_lfsr[0];
  end

  // a console write on a full FIFO may still leave WAIT if the consumer
  // pops in the same cycle
  assign w_pop  = !w_con_empty && bus.con_ready;
  assign w_go   = (r_state == ST_WAIT) && w_wait_done &&
                  !(w_is_wr && w_is_con && w_con_full && !w_pop);
  assign w_push = w_go && w_is_wr && w_is_con;

  picorv32_sim_fifo #(.W(8), .DEPTH(CON_DEPTH)) u_con (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_din  (r_wdata[7:0]),
    .i_pop  (w_pop),
    .o_dout (bus.con_data),
    .o_empty(w_con_empty),
    .o_full (w_con_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
      r_mem_ready <= 1'b0;
      r_dbg_ready <= 1'b0;
      r_rdata     <= '0;
      r_dbg_rdata <= '0;
      r_exited    <= 1'b0;
      r_exit_code <= '0;
      r_err       <= 1'b0;
    end else begin
      r_lfsr      <= xorshift32(r_lfsr);
      r_mem_ready <= 1'b0;
      r_dbg_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // the debug completion cycle is still IDLE; hold off until it ends
          if (!r_mem_ready && !r_dbg_ready) begin
            if (bus.dbg_valid) begin
              r_dbg_we    <= bus.dbg_we;
              r_dbg_addr  <= bus.dbg_addr;
              r_dbg_wdata <= bus.dbg_wdata;
              r_state     <= ST_DBG;
            end else if (bus.mem_valid) begin
              r_addr  <= bus.mem_addr;
              r_wdata <= bus.mem_wdata;
              r_wstrb <= bus.mem_wstrb;
              r_cnt   <= 8'(FIXED_WAIT);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          if (w_go) begin
            r_mem_ready <= 1'b1;
            r_rdata     <= (!w_is_wr && w_ram_ok) ? w_rd_word : 32'd0;
            if (w_oor) r_err <= 1'b1;
            if (w_is_wr && w_is_exit && !r_exited) begin
              r_exited    <= 1'b1;
              r_exit_code <= r_wdata;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        ST_DBG: begin
          r_dbg_ready <= 1'b1;
          r_dbg_rdata <= (!r_dbg_we && !w_dbg_oor) ? r_ram[w_dbg_idx] : 8'd0;
          if (w_dbg_oor) r_err <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM is never cleared; writes land on the same edge the response is
  // registered, so a reset before that edge leaves memory untouched
  always_ff @(posedge clk) begin
    if (!reset && w_go && w_is_wr && w_ram_ok) begin
      for (int i = 0; i < 4; i++)
        if (r_wstrb[i]) r_ram[w_idx | AW'(i)] <= r_wdata[8*i +: 8];
    end
    if (!reset && (r_state == ST_DBG) && r_dbg_we && !w_dbg_oor)
      r_ram[w_dbg_idx] <= r_dbg_wdata;
  end

  assign bus.mem_ready = r_mem_ready;
  assign bus.mem_rdata = r_rdata;
  assign bus.con_valid = !w_con_empty;
  assign bus.dbg_ready = r_dbg_ready;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.exited    = r_exited;
  assign bus.exit_code = r_exit_code;
  assign bus.err       = r_err;

  assign w_unused = &{1'b0, bus.mem_instr, r_addr[1:0]};
endmodule
